res_desp_seq: RTL and testbench



---
 rtl/res_desp_seq.sv | 107 ++++++++++
 tb/tb_res_desp_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/res_desp_seq.sv
// Sequential subtract-with-borrow followed by a left shift of 0/1/2/SH3 bits, one bit per clock.
// Operands and result each move through a valid/ready handshake; one operation in flight.
module res_desp_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SH3   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   s_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StSub, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  logic [WIDTH-1:0] r_data;
  logic             r_borrow;
  logic             r_ovf;
  logic [CW-1:0]    r_shamt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_shamt;
  logic [WIDTH:0]   w_diff;

  always_comb begin
    w_shamt = '0;
    case (sel)
      2'b00:   w_shamt = '0;
      2'b01:   w_shamt = CW'(1);
      2'b10:   w_shamt = CW'(2);
      default: w_shamt = CW'(SH3);
    endcase
  end

  // Zero-extended subtraction: the extra MSB is the borrow.
  assign w_diff = {1'b0, r_op1} - {1'b0, r_op2};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (in_valid) w_state_next = StSub;
      StSub:   w_state_next = (r_shamt != '0) ? StShift : StDone;
      StShift: if (r_cnt == CW'(1)) w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_shamt  <= '0;
      r_data   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_op1   <= op1;
            r_op2   <= op2;
            r_shamt <= w_shamt;
          end
        end
        StSub: begin
          r_borrow <= w_diff[WIDTH];
          r_data   <= w_diff[WIDTH-1:0];
          r_ovf    <= 1'b0;
          r_cnt    <= r_shamt;
        end
        StShift: begin
          r_data <= {r_data[WIDTH-2:0], 1'b0};
          r_ovf  <= r_ovf | r_data[WIDTH-1];
          r_cnt  <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign s_out     = {r_borrow, r_data};
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_res_desp_seq.sv
// Directed bench for res_desp_seq: latency, result, backpressure and async reset mid-shift.
module tb_res_desp_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] op1;
  logic [7:0] op2;
  logic [1:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] s_out;
  logic       ovf;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  res_desp_seq #(.WIDTH(8), .SH3(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op1       (op1),
    .op2       (op2),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_out     (s_out),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Called just after a clock edge with the DUT idle. Returns with the result presented.
  task automatic launch_and_wait(input string tag, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] s, input int exp_lat,
                                 input logic [8:0] exp_s, input logic exp_ovf);
    int lat;
    op1      = a;
    op2      = b;
    sel      = s;
    in_valid = 1'b1;
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Post-accept input changes must be ignored.
    op1 = ~a;
    op2 = a;
    sel = ~s;
    lat = 1;
    while (!out_valid && lat < 50) begin
      check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " s_out"}, 32'(s_out), 32'(exp_s));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, " in_ready in done"}, 32'(in_ready), 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    op1       = '0;
    op2       = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset s_out", 32'(s_out), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    launch_and_wait("t1", 8'h10, 8'h03, 2'b01, 3, 9'h01A, 1'b0);
    handshake("t1");
    launch_and_wait("t2", 8'h03, 8'h05, 2'b00, 2, 9'h1FE, 1'b0);
    handshake("t2");
    launch_and_wait("t3", 8'h03, 8'h05, 2'b11, 7, 9'h1C0, 1'b1);
    handshake("t3");
    launch_and_wait("t4", 8'h80, 8'h00, 2'b10, 4, 9'h000, 1'b1);
    handshake("t4");

    // Backpressure: result must hold for 10 cycles with out_ready low.
    launch_and_wait("bp", 8'h10, 8'h03, 2'b01, 3, 9'h01A, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp out_valid hold", 32'(out_valid), 32'd1);
      check("bp s_out hold", 32'(s_out), 32'h01A);
      check("bp ovf hold", 32'(ovf), 32'd0);
      check("bp in_ready hold", 32'(in_ready), 32'd0);
    end
    handshake("bp");
    launch_and_wait("bp next", 8'h07, 8'h07, 2'b11, 7, 9'h000, 1'b0);
    handshake("bp next");

    // Async reset during the third shift cycle of a sel=11 operation.
    op1      = 8'h03;
    op2      = 8'h05;
    sel      = 2'b11;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst s_out", 32'(s_out), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      check("rst no result", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    launch_and_wait("post rst", 8'h22, 8'h22, 2'b10, 4, 9'h000, 1'b0);
    handshake("post rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
